// File: rtl/branch_resolve.sv
// Resolves RISC-V branches/jumps from ALU NZCV flags and drives a registered fetch redirect plus flush.
// Optional BRANCH_STATS_EN adds taken/not-taken/stall counters.
module branch_resolve #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic            br_is_jump,
  input  logic [2:0]      br_funct3,
  input  logic [XLEN-1:0] br_target,
  input  logic [3:0]      flags,
  output logic            redir_valid,
  input  logic            redir_ready,
  output logic [XLEN-1:0] redir_pc,
  output logic            flush,
  output logic            res_valid,
  output logic            res_taken,
  output logic            res_err
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_not_taken,
  output logic [CNT_W-1:0] stat_stall
`endif
);

  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] REDIRECT = 2'b01;
  localparam logic [1:0] FLUSH    = 2'b10;
  localparam int FCW = $clog2(FLUSH_CYCLES + 2);

  logic [1:0]      state_q, state_d;
  logic [FCW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            res_valid_q, res_taken_q, res_err_q;

  logic            flag_n, flag_z, flag_c, flag_v;
  logic            cond, illegal, misalign, err, go_taken, accept;
  logic [XLEN-1:0] tgt_clr;

  assign {flag_n, flag_z, flag_c, flag_v} = flags;
  assign tgt_clr = br_target & ~XLEN'(1);

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (br_funct3)
      3'b000:  cond = flag_z;
      3'b001:  cond = ~flag_z;
      3'b100:  cond = flag_n ^ flag_v;
      3'b101:  cond = ~(flag_n ^ flag_v);
      3'b110:  cond = ~flag_c;
      3'b111:  cond = flag_c;
      default: illegal = 1'b1;
    endcase
    if (br_is_jump) begin
      cond    = 1'b1;
      illegal = 1'b0;
    end
  end

  // A taken branch to a non-word-aligned target is reported instead of redirected.
  assign misalign = cond & tgt_clr[1];
  assign err      = illegal | misalign;
  assign go_taken = cond & ~err;
  assign accept   = br_valid & br_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (accept && go_taken) begin
          pc_d    = tgt_clr;
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        if (redir_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = FLUSH;
            cnt_d   = FCW'(FLUSH_CYCLES);
          end
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - FCW'(1);
        if (cnt_q <= FCW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pc_q        <= '0;
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      res_valid_q <= accept;
      res_taken_q <= accept & go_taken;
      res_err_q   <= accept & err;
    end
  end

  assign br_ready    = (state_q == IDLE);
  assign redir_valid = (state_q == REDIRECT);
  assign flush       = (state_q != IDLE);
  assign redir_pc    = pc_q;
  assign res_valid   = res_valid_q;
  assign res_taken   = res_taken_q;
  assign res_err     = res_err_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] st_taken_q, st_nt_q, st_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_taken_q <= '0;
      st_nt_q    <= '0;
      st_stall_q <= '0;
    end else begin
      if (res_valid_q && res_taken_q)               st_taken_q <= st_taken_q + CNT_W'(1);
      if (res_valid_q && !res_taken_q && !res_err_q) st_nt_q    <= st_nt_q + CNT_W'(1);
      if (state_q == REDIRECT && !redir_ready)       st_stall_q <= st_stall_q + CNT_W'(1);
    end
  end

  assign stat_taken     = st_taken_q;
  assign stat_not_taken = st_nt_q;
  assign stat_stall     = st_stall_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: result and redirect scoreboards checked by negedge monitors.
module tb_branch_resolve;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_valid, br_ready, br_is_jump;
  logic [2:0]  br_funct3;
  logic [31:0] br_target;
  logic [3:0]  flags;
  logic        redir_valid, redir_ready;
  logic [31:0] redir_pc;
  logic        flush, res_valid, res_taken, res_err;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_taken, stat_not_taken, stat_stall;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0]  res_q[$];   // {taken, err}
  logic [31:0] pc_q[$];

  always #5 clk = ~clk;

  branch_resolve #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .br_valid(br_valid), .br_ready(br_ready), .br_is_jump(br_is_jump),
    .br_funct3(br_funct3), .br_target(br_target), .flags(flags),
    .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
    .flush(flush), .res_valid(res_valid), .res_taken(res_taken), .res_err(res_err)
`ifdef BRANCH_STATS_EN
    , .stat_taken(stat_taken), .stat_not_taken(stat_not_taken), .stat_stall(stat_stall)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Result monitor
  always @(negedge clk) begin
    if (rst_n && (res_valid || res_err)) begin
      if (res_q.size() == 0) begin
        check("unexpected_result", 32'(res_valid), 32'd0);
      end else begin
        logic [1:0] e;
        e = res_q.pop_front();
        check("res_valid", 32'(res_valid), 32'd1);
        check("res_taken", 32'(res_taken), 32'(e[1]));
        check("res_err", 32'(res_err), 32'(e[0]));
      end
    end
  end

  // Redirect monitor: handshake completes at the following posedge
  always @(negedge clk) begin
    if (rst_n && redir_valid && redir_ready) begin
      if (pc_q.size() == 0) begin
        check("unexpected_redirect", 32'(redir_valid), 32'd0);
      end else begin
        logic [31:0] e;
        e = pc_q.pop_front();
        check("redir_pc", redir_pc, e);
      end
    end
  end

  task automatic issue(input logic jump, input logic [2:0] f3, input logic [31:0] tgt,
                       input logic [3:0] fl, input logic exp_taken, input logic exp_err,
                       input logic [31:0] exp_pc);
    check("br_ready_before_issue", 32'(br_ready), 32'd1);
    br_valid   = 1'b1;
    br_is_jump = jump;
    br_funct3  = f3;
    br_target  = tgt;
    flags      = fl;
    res_q.push_back({exp_taken, exp_err});
    if (exp_taken) pc_q.push_back(exp_pc);
    @(posedge clk);
    #1 br_valid = 1'b0;
  endtask

  // Counts flush cycles from the current cycle until br_ready returns
  task automatic count_flush(input string name, input int exp);
    int n = 0;
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (flush) n++;
      if (br_ready) done = 1;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_flush_cycles"}, 32'(n), 32'(exp));
  endtask

  task automatic run(input logic jump, input logic [2:0] f3, input logic [31:0] tgt,
                     input logic [3:0] fl, input logic exp_taken, input logic exp_err,
                     input logic [31:0] exp_pc, input string name);
    issue(jump, f3, tgt, fl, exp_taken, exp_err, exp_pc);
    if (exp_taken) count_flush(name, 3);
    else begin
      @(negedge clk);
      check({name, "_nt_ready"}, 32'(br_ready), 32'd1);
      check({name, "_nt_no_redir"}, 32'(redir_valid), 32'd0);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; br_valid = 1'b0; br_is_jump = 1'b0; br_funct3 = 3'b000;
    br_target = 32'h0; flags = 4'h0; redir_ready = 1'b1;
    #3;
    check("rst_br_ready", 32'(br_ready), 32'd1);
    check("rst_redir_valid", 32'(redir_valid), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_redir_pc", redir_pc, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(1'b0, 3'b000, 32'h100, 4'b0100, 1'b1, 1'b0, 32'h100, "beq");
    run(1'b0, 3'b110, 32'h200, 4'b0010, 1'b0, 1'b0, 32'h0,   "bltu");
    run(1'b0, 3'b111, 32'h200, 4'b0010, 1'b1, 1'b0, 32'h200, "bgeu");
    run(1'b0, 3'b100, 32'h300, 4'b1001, 1'b0, 1'b0, 32'h0,   "blt_nv11");
    run(1'b0, 3'b101, 32'h304, 4'b1001, 1'b1, 1'b0, 32'h304, "bge_nv11");
    run(1'b0, 3'b100, 32'h308, 4'b0001, 1'b1, 1'b0, 32'h308, "blt_nv01");
    run(1'b0, 3'b101, 32'h30c, 4'b0001, 1'b0, 1'b0, 32'h0,   "bge_nv01");

    // Stalled jump
    redir_ready = 1'b0;
    issue(1'b1, 3'b010, 32'h400, 4'b0000, 1'b1, 1'b0, 32'h400);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_redir_valid", 32'(redir_valid), 32'd1);
      check("stall_redir_pc", redir_pc, 32'h400);
      check("stall_br_ready", 32'(br_ready), 32'd0);
      @(posedge clk);
    end
    #1 redir_ready = 1'b1;
    count_flush("stall", 3);
`ifdef BRANCH_STATS_EN
    check("stat_stall", stat_stall, 32'd5);
`endif

    // Errors and alignment
    run(1'b0, 3'b010, 32'h500, 4'b0100, 1'b0, 1'b1, 32'h0,   "illegal_f3");
    run(1'b1, 3'b000, 32'h102, 4'b0000, 1'b0, 1'b1, 32'h0,   "misaligned");
    run(1'b1, 3'b000, 32'h101, 4'b0000, 1'b1, 1'b0, 32'h100, "bit0_clear");

    // Back-to-back not-taken requests
    issue(1'b0, 3'b001, 32'h600, 4'b0100, 1'b0, 1'b0, 32'h0);
    issue(1'b0, 3'b000, 32'h604, 4'b0000, 1'b0, 1'b0, 32'h0);
    issue(1'b0, 3'b110, 32'h608, 4'b0010, 1'b0, 1'b0, 32'h0);
    @(negedge clk);

    // Reset in FLUSH with counter at 1
    issue(1'b1, 3'b000, 32'h700, 4'b0000, 1'b1, 1'b0, 32'h700);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_rst_flush", 32'(flush), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_flush", 32'(flush), 32'd0);
    check("arst_redir_valid", 32'(redir_valid), 32'd0);
    check("arst_br_ready", 32'(br_ready), 32'd1);
    check("arst_redir_pc", redir_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, 3'b001, 32'h800, 4'b0100, 1'b0, 1'b0, 32'h0, "bne_after_rst");

    repeat (3) @(negedge clk);
    check("res_queue_empty", 32'(res_q.size()), 32'd0);
    check("pc_queue_empty", 32'(pc_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
